// File: rtl/pipe_column_gen.sv
`default_nettype none
// ============================================================================
// Module   : pipe_column_gen
// Purpose  : Produces the obstacle (red) column stream for the collision/score
//            counter, one ROWS-tall column per scroll step. Pipe columns are
//            solid apart from a pseudo-random gap; the space columns between
//            pipes are empty. Row 0 is the ground and stays lit while running.
//            The generator freezes (HALT) on gameEnd until the next reset.
// Ports    : clk        - system clock
//            reset      - synchronous active-high reset
//            start      - one-cycle pulse, begins scrolling from IDLE
//            gameEnd    - level, freezes the generator
//            red        - current obstacle column, bit 0 = ground
//            gap_row    - base row of the current/last gap
//            pipe_done  - one-cycle pulse when a pipe has scrolled past
//            pipe_count - pipes completed, saturating at 255
// Options  : PIPE_NARROW_EN - when defined, the gap shrinks by one row per
//            8 completed pipes, never below 2 rows.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_column_gen #(
    parameter int          ROWS      = 16,
    parameter int          GAP_H     = 4,
    parameter int          PIPE_W    = 2,
    parameter int          SPACE_W   = 3,
    parameter int          STEP_DIV  = 4,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            gameEnd,
    output logic [ROWS-1:0] red,
    output logic [3:0]      gap_row,
    output logic            pipe_done,
    output logic [7:0]      pipe_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPACE = 2'd1,
        PIPE  = 2'd2,
        HALT  = 2'd3
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [7:0]          c_SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam int                  c_DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int                  c_COL_MAX  = (SPACE_W > PIPE_W) ? SPACE_W : PIPE_W;
    localparam int                  c_COL_W    = $clog2(c_COL_MAX + 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(STEP_DIV - 1);
    localparam logic [c_COL_W-1:0]  c_SPACE_N  = c_COL_W'(SPACE_W);
    localparam logic [c_COL_W-1:0]  c_PIPE_N   = c_COL_W'(PIPE_W);
    localparam logic [c_COL_W-1:0]  c_COL_ONE  = c_COL_W'(1);
    localparam logic [ROWS-1:0]     c_GROUND   = ROWS'(1);

    state_t               r_state, w_state_n;
    logic [c_DIV_W-1:0]   r_div,   w_div_n;
    logic [c_COL_W-1:0]   r_col,   w_col_n;
    logic [7:0]           r_lfsr,  w_lfsr_n;
    logic [ROWS-1:0]      r_red,   w_red_n;
    logic [3:0]           r_gap,   w_gap_n;
    logic                 r_done,  w_done_n;
    logic [7:0]           r_count, w_count_n;

    logic                 w_step;
    logic [7:0]           w_lfsr_adv;
    int                   w_gap_h;
    int                   w_gap_base;
    logic [ROWS-1:0]      w_pipe_col;

    assign w_step     = (r_div == c_DIV_LAST);
    assign w_lfsr_adv = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    // Effective gap height for the pipe that would start on this step.
    always_comb begin
`ifdef PIPE_NARROW_EN
        w_gap_h = GAP_H - int'({27'd0, r_count[7:3]});
        if (w_gap_h < 2) begin
            w_gap_h = 2;
        end
`else
        w_gap_h = GAP_H;
`endif
    end

    // Gap base is offset by one so the gap can never open the ground row.
    always_comb begin
        w_gap_base = 1 + (int'({28'd0, w_lfsr_adv[3:0]}) % (ROWS - w_gap_h));
        for (int r = 0; r < ROWS; r++) begin
            w_pipe_col[r] = !((r >= w_gap_base) && (r < w_gap_base + w_gap_h));
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_div_n   = r_div;
        w_col_n   = r_col;
        w_lfsr_n  = r_lfsr;
        w_red_n   = r_red;
        w_gap_n   = r_gap;
        w_done_n  = 1'b0;
        w_count_n = r_count;

        case (r_state)
            IDLE: begin
                w_red_n = c_GROUND;
                if (start) begin
                    w_state_n = SPACE;
                    w_div_n   = '0;
                    w_col_n   = '0;
                end
            end
            SPACE, PIPE: begin
                // gameEnd beats a coincident step: nothing else moves.
                if (gameEnd) begin
                    w_state_n = HALT;
                end else begin
                    w_div_n = w_step ? '0 : r_div + 1'b1;
                    if (w_step) begin
                        if (r_state == SPACE) begin
                            if (r_col == c_SPACE_N) begin
                                // Entering PIPE emits the first pipe column.
                                w_state_n = PIPE;
                                w_lfsr_n  = w_lfsr_adv;
                                w_gap_n   = 4'(w_gap_base);
                                w_red_n   = w_pipe_col;
                                w_col_n   = c_COL_ONE;
                            end else begin
                                w_red_n = c_GROUND;
                                w_col_n = r_col + 1'b1;
                            end
                        end else begin
                            if (r_col == c_PIPE_N) begin
                                // Leaving PIPE emits the first space column.
                                w_state_n = SPACE;
                                w_red_n   = c_GROUND;
                                w_col_n   = c_COL_ONE;
                                w_done_n  = 1'b1;
                                w_count_n = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
                            end else begin
                                w_col_n = r_col + 1'b1;
                            end
                        end
                    end
                end
            end
            default: begin
                // HALT: everything holds until reset.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_col   <= '0;
            r_lfsr  <= c_SEED;
            r_red   <= c_GROUND;
            r_gap   <= 4'd0;
            r_done  <= 1'b0;
            r_count <= 8'd0;
        end else begin
            r_state <= w_state_n;
            r_div   <= w_div_n;
            r_col   <= w_col_n;
            r_lfsr  <= w_lfsr_n;
            r_red   <= w_red_n;
            r_gap   <= w_gap_n;
            r_done  <= w_done_n;
            r_count <= w_count_n;
        end
    end

    assign red        = r_red;
    assign gap_row    = r_gap;
    assign pipe_done  = r_done;
    assign pipe_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_column_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_column_gen
// Purpose  : Self-checking bench for pipe_column_gen (default build). Expected
//            column values are queued against a target edge number, counted
//            from the edge that samples start, and compared as those edges
//            arrive; a long run tracks gaps and the pipe counter with a small
//            reference LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_column_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        gameEnd;
    logic [15:0] red;
    logic [3:0]  gap_row;
    logic        pipe_done;
    logic [7:0]  pipe_count;

    pipe_column_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .gameEnd    (gameEnd),
        .red        (red),
        .gap_row    (gap_row),
        .pipe_done  (pipe_done),
        .pipe_count (pipe_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_n;
        logic [15:0] red;
        logic [3:0]  gap;
        logic        done;
        logic [7:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cur_edge;

    function automatic logic [7:0] f_lfsr(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [3:0] f_base(input logic [7:0] l);
        return 4'(1 + (int'(l[3:0]) % 12));
    endfunction

    function automatic logic [15:0] f_col(input logic [3:0] base);
        logic [15:0] m;
        m = 16'hFFFF;
        for (int r = 0; r < 4; r++) m[int'(base) + r] = 1'b0;
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input int e, input logic [15:0] r, input logic [3:0] g,
                        input logic d, input logic [7:0] c);
        exp_t x;
        x.edge_n = e; x.red = r; x.gap = g; x.done = d; x.cnt = c;
        q.push_back(x);
    endtask

    // One clock edge; compare every queued expectation due at this edge.
    task automatic tick();
        exp_t x;
        @(posedge clk);
        cur_edge++;
        #1;
        while (q.size() > 0 && q[0].edge_n <= cur_edge) begin
            x = q.pop_front();
            check($sformatf("red@%0d", x.edge_n),   32'(red),        32'(x.red));
            check($sformatf("gap@%0d", x.edge_n),   32'(gap_row),    32'(x.gap));
            check($sformatf("done@%0d", x.edge_n),  32'(pipe_done),  32'(x.done));
            check($sformatf("count@%0d", x.edge_n), 32'(pipe_count), 32'(x.cnt));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        gameEnd = 1'b0;
        start   = 1'b0;
        check("rst_red",   32'(red),        32'h0001);
        check("rst_gap",   32'(gap_row),    32'h0);
        check("rst_done",  32'(pipe_done),  32'h0);
        check("rst_count", 32'(pipe_count), 32'h0);
    endtask

    task automatic start_run();
        cur_edge = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [7:0]  m_lfsr;
    logic [7:0]  m_cnt;
    logic [15:0] prev_red;
    logic        prev_done;
    int          pipes;
    int          cyc;

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        gameEnd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Idle with no start: nothing moves.
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            check("idle_red",   32'(red),        32'h0001);
            check("idle_done",  32'(pipe_done),  32'h0);
            check("idle_count", 32'(pipe_count), 32'h0);
        end

        // Default run: spaces at 4/8/12, pipe at 16/20, space at 24, pipe 2 at 36.
        for (int e = 0;  e <= 15; e++) push(e, 16'h0001, 4'd0,  1'b0, 8'd0);
        for (int e = 16; e <= 23; e++) push(e, 16'h87FF, 4'd11, 1'b0, 8'd0);
        push(24, 16'h0001, 4'd11, 1'b1, 8'd1);
        for (int e = 25; e <= 35; e++) push(e, 16'h0001, 4'd11, 1'b0, 8'd1);
        for (int e = 36; e <= 39; e++) push(e, 16'hFC3F, 4'd6,  1'b0, 8'd1);
        start_run();
        while (cur_edge < 39) tick();
        check("queue_empty_run", 32'(q.size()), 32'd0);

        // Long run to 300 completed pipes, continuing from inside pipe 2.
        m_lfsr    = 8'h95;
        m_cnt     = 8'd1;
        pipes     = 1;
        cyc       = 0;
        prev_red  = red;
        prev_done = pipe_done;
        while (pipes < 300 && cyc < 7000) begin
            @(posedge clk);
            #1;
            cyc++;
            check("ground", 32'(red[0]), 32'h1);
            if (prev_done) check("done_width", 32'(pipe_done), 32'h0);
            if (prev_red == 16'h0001 && red != 16'h0001) begin
                m_lfsr = f_lfsr(m_lfsr);
                check("long_gap",   32'(gap_row), 32'(f_base(m_lfsr)));
                check("long_range", 32'(gap_row >= 4'd1 && gap_row <= 4'd12), 32'h1);
                check("long_col",   32'(red), 32'(f_col(f_base(m_lfsr))));
            end
            if (pipe_done) begin
                pipes++;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                check("long_count", 32'(pipe_count), 32'(m_cnt));
                check("done_red",   32'(red), 32'h0001);
            end
            prev_red  = red;
            prev_done = pipe_done;
        end
        check("long_pipes", 32'(pipes >= 300), 32'h1);
        check("saturate",   32'(pipe_count), 32'd255);

        // gameEnd mid-pipe: frozen at the first pipe column.
        do_reset();
        for (int e = 18; e <= 40; e++) push(e, 16'h87FF, 4'd11, 1'b0, 8'd0);
        start_run();
        while (cur_edge < 17) tick();
        gameEnd = 1'b1;
        while (cur_edge < 40) tick();
        check("queue_empty_halt", 32'(q.size()), 32'd0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("halt_start_red", 32'(red), 32'h87FF);
        do_reset();

        // gameEnd in IDLE is ignored; then gameEnd coincident with the step at 24.
        gameEnd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        gameEnd = 1'b0;
        check("idle_gameend_red", 32'(red), 32'h0001);
        push(20, 16'h87FF, 4'd11, 1'b0, 8'd0);
        for (int e = 24; e <= 30; e++) push(e, 16'h87FF, 4'd11, 1'b0, 8'd0);
        start_run();
        while (cur_edge < 23) tick();
        gameEnd = 1'b1;
        while (cur_edge < 30) tick();
        check("queue_empty_coinc", 32'(q.size()), 32'd0);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
